// File: rtl/man_align_shift.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : man_align_shift
//  Brief    : FP add/sub alignment stage. Right-shifts the smaller mantissa by
//             the exponent difference, forms G/R/S, flags effective subtract.
//  Revision : 1.0 - initial release
// ============================================================================
module man_align_shift #(
    parameter int SIZE_MAN = 24,
    parameter int SIZE_EXP = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign_max,
    input  logic                  i_sign_min,
    input  logic [SIZE_MAN-1:0]   i_man_max,
    input  logic [SIZE_MAN-1:0]   i_man_min,
    input  logic [SIZE_EXP-1:0]   i_exp_diff,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign_max,
    output logic                  o_eff_sub,
    output logic [SIZE_MAN+2:0]   o_man_max_ext,
    output logic [SIZE_MAN+2:0]   o_man_min_ext
);

    // Mantissa plus guard and round positions
    localparam int c_EXT_W = SIZE_MAN + 2;

    // Stage 1: input register
    logic                  r_s1_v;
    logic                  r_s1_sign_max;
    logic                  r_s1_sign_min;
    logic [SIZE_MAN-1:0]   r_s1_man_max;
    logic [SIZE_MAN-1:0]   r_s1_man_min;
    logic [SIZE_EXP-1:0]   r_s1_exp_diff;

    // Stage 2: output register
    logic                  r_s2_v;
    logic                  r_s2_sign_max;
    logic                  r_s2_eff_sub;
    logic [SIZE_MAN+2:0]   r_s2_man_max_ext;
    logic [SIZE_MAN+2:0]   r_s2_man_min_ext;

    logic                  w_s1_free;
    logic                  w_s2_free;
    logic [31:0]           w_d_wide;
    logic                  w_in_range;
    logic [c_EXT_W-1:0]    w_ext;
    logic [c_EXT_W-1:0]    w_ones;
    logic [c_EXT_W-1:0]    w_mask;
    logic [c_EXT_W-1:0]    w_sh;
    logic                  w_sticky;
    logic [SIZE_MAN+2:0]   w_man_min_ext;
    logic [SIZE_MAN+2:0]   w_man_max_ext;

    assign w_s2_free = !r_s2_v || i_ready;
    assign w_s1_free = !r_s1_v || w_s2_free;
    assign o_ready   = w_s1_free;

    // Range test done at 32 bits so any SIZE_EXP compares without wrap
    assign w_d_wide   = 32'(r_s1_exp_diff);
    assign w_in_range = w_d_wide < 32'(c_EXT_W);

    assign w_ext  = {r_s1_man_min, 2'b00};
    assign w_ones = '1;
    assign w_mask = ~(w_ones << r_s1_exp_diff);

    always_comb begin
        w_sh     = '0;
        w_sticky = 1'b0;
        if (w_in_range) begin
            w_sh     = w_ext >> r_s1_exp_diff;
            w_sticky = |(w_ext & w_mask);
        end else begin
            w_sh     = '0;
            w_sticky = |r_s1_man_min;
        end
    end

    assign w_man_min_ext = {w_sh, w_sticky};
    assign w_man_max_ext = {r_s1_man_max, 3'b000};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v        <= 1'b0;
            r_s1_sign_max <= 1'b0;
            r_s1_sign_min <= 1'b0;
            r_s1_man_max  <= '0;
            r_s1_man_min  <= '0;
            r_s1_exp_diff <= '0;
        end else if (w_s1_free) begin
            r_s1_v        <= i_valid;
            r_s1_sign_max <= i_sign_max;
            r_s1_sign_min <= i_sign_min;
            r_s1_man_max  <= i_man_max;
            r_s1_man_min  <= i_man_min;
            r_s1_exp_diff <= i_exp_diff;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_v           <= 1'b0;
            r_s2_sign_max    <= 1'b0;
            r_s2_eff_sub     <= 1'b0;
            r_s2_man_max_ext <= '0;
            r_s2_man_min_ext <= '0;
        end else if (w_s2_free) begin
            r_s2_v           <= r_s1_v;
            r_s2_sign_max    <= r_s1_sign_max;
            r_s2_eff_sub     <= r_s1_sign_max ^ r_s1_sign_min;
            r_s2_man_max_ext <= w_man_max_ext;
            r_s2_man_min_ext <= w_man_min_ext;
        end
    end

    assign o_valid       = r_s2_v;
    assign o_sign_max    = r_s2_sign_max;
    assign o_eff_sub     = r_s2_eff_sub;
    assign o_man_max_ext = r_s2_man_max_ext;
    assign o_man_min_ext = r_s2_man_min_ext;

endmodule
`default_nettype wire

// File: tb/tb_man_align_shift.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_man_align_shift
//  Brief    : Directed self-checking bench for the mantissa alignment stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_man_align_shift;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign_max;
    logic        i_sign_min;
    logic [23:0] i_man_max;
    logic [23:0] i_man_min;
    logic [7:0]  i_exp_diff;
    logic        o_valid;
    logic        i_ready;
    logic        o_sign_max;
    logic        o_eff_sub;
    logic [26:0] o_man_max_ext;
    logic [26:0] o_man_min_ext;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream table: man_min = 24'h800001 shifted by each d
    logic [7:0]  st_d   [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd24, 8'd25, 8'd26, 8'd255};
    logic [26:0] st_min [8] = '{27'h4000008, 27'h2000004, 27'h1000002, 27'h0800001,
                                27'h0000005, 27'h0000003, 27'h0000001, 27'h0000001};

    always #5 clk = ~clk;

    man_align_shift #(
        .SIZE_MAN (24),
        .SIZE_EXP (8)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sign_max    (i_sign_max),
        .i_sign_min    (i_sign_min),
        .i_man_max     (i_man_max),
        .i_man_min     (i_man_min),
        .i_exp_diff    (i_exp_diff),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sign_max    (o_sign_max),
        .o_eff_sub     (o_eff_sub),
        .o_man_max_ext (o_man_max_ext),
        .o_man_min_ext (o_man_min_ext)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic smax, input logic smin, input logic [23:0] mmax,
                         input logic [23:0] mmin, input logic [7:0] d);
        i_sign_max = smax;
        i_sign_min = smin;
        i_man_max  = mmax;
        i_man_min  = mmin;
        i_exp_diff = d;
    endtask

    // One isolated transfer through an empty pipeline
    task automatic single(input string tag, input logic smax, input logic smin,
                          input logic [23:0] mmax, input logic [23:0] mmin,
                          input logic [7:0] d, input logic [26:0] exp_min);
        i_ready = 1'b1;
        i_valid = 1'b1;
        drive(smax, smin, mmax, mmin, d);
        step();
        i_valid = 1'b0;
        chk({tag, " valid_lat1"}, 32'(o_valid), 32'd0);
        step();
        chk({tag, " valid_lat2"}, 32'(o_valid), 32'd1);
        chk({tag, " man_min_ext"}, 32'(o_man_min_ext), 32'(exp_min));
        chk({tag, " man_max_ext"}, 32'(o_man_max_ext), 32'({mmax, 3'b000}));
        chk({tag, " eff_sub"}, 32'(o_eff_sub), 32'(smax ^ smin));
        chk({tag, " sign_max"}, 32'(o_sign_max), 32'(smax));
        step();
        chk({tag, " drained"}, 32'(o_valid), 32'd0);
    endtask

    // Eight back-to-back inputs with an optional downstream stall window
    task automatic run_stream(input string tag, input int stall_start, input int stall_len);
        int   in_idx  = 0;
        int   out_idx = 0;
        logic stall;
        for (int cyc = 0; cyc <= 10 + stall_len; cyc++) begin
            stall   = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            i_ready = !stall;
            if (in_idx < 8) begin
                i_valid = 1'b1;
                drive(in_idx[0], 1'b0, 24'(in_idx + 1), 24'h800001, st_d[in_idx]);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            chk({tag, " o_ready"}, 32'(o_ready), 32'(!stall));
            chk({tag, " o_valid"}, 32'(o_valid), 32'((cyc >= 2) && (cyc <= 9 + stall_len)));
            if (o_valid === 1'b1 && out_idx < 8) begin
                chk({tag, " man_min_ext"}, 32'(o_man_min_ext), 32'(st_min[out_idx]));
                chk({tag, " man_max_ext"}, 32'(o_man_max_ext), 32'(out_idx + 1) << 3);
                chk({tag, " eff_sub"}, 32'(o_eff_sub), 32'(out_idx[0]));
                chk({tag, " sign_max"}, 32'(o_sign_max), 32'(out_idx[0]));
                if (!stall) out_idx++;
            end
            if (i_valid && o_ready) in_idx++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        chk({tag, " outputs_seen"}, 32'(out_idx), 32'd8);
        chk({tag, " inputs_taken"}, 32'(in_idx), 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        drive(1'b0, 1'b0, 24'h0, 24'h0, 8'h0);
        step();
        step();
        chk("reset o_valid", 32'(o_valid), 32'd0);
        chk("reset o_ready", 32'(o_ready), 32'd1);
        chk("reset man_min", 32'(o_man_min_ext), 32'd0);
        chk("reset man_max", 32'(o_man_max_ext), 32'd0);
        chk("reset eff_sub", 32'(o_eff_sub), 32'd0);
        chk("reset sign_max", 32'(o_sign_max), 32'd0);
        i_rst = 1'b0;
        step();

        single("d0",        1'b0, 1'b0, 24'hFFFFFF, 24'h800001, 8'd0,   27'h4000008);
        single("d1",        1'b0, 1'b0, 24'hFFFFFF, 24'h800001, 8'd1,   27'h2000004);
        single("d3_sticky", 1'b0, 1'b0, 24'hFFFFFF, 24'h800001, 8'd3,   27'h0800001);
        single("d2_sub",    1'b0, 1'b1, 24'hC00000, 24'h800001, 8'd2,   27'h1000002);
        single("d24_neg",   1'b1, 1'b0, 24'h900000, 24'h800001, 8'd24,  27'h0000005);
        single("d25",       1'b1, 1'b1, 24'h800000, 24'h800001, 8'd25,  27'h0000003);
        single("d26",       1'b0, 1'b0, 24'h800000, 24'h000001, 8'd26,  27'h0000001);
        single("d255",      1'b0, 1'b0, 24'h800000, 24'h000001, 8'd255, 27'h0000001);
        single("d255_zero", 1'b0, 1'b0, 24'h800000, 24'h000000, 8'd255, 27'h0000000);
        single("d255_full", 1'b0, 1'b1, 24'h800000, 24'hFFFFFF, 8'd255, 27'h0000001);

        run_stream("stream", 100, 0);
        run_stream("stall", 4, 3);

        // Fill both stages while downstream is blocked, then reset
        i_ready = 1'b0;
        i_valid = 1'b1;
        drive(1'b1, 1'b0, 24'hABCDEF, 24'h800001, 8'd3);
        step();
        drive(1'b0, 1'b0, 24'h123456, 24'h800001, 8'd1);
        step();
        chk("full o_valid", 32'(o_valid), 32'd1);
        chk("full o_ready", 32'(o_ready), 32'd0);
        chk("full man_min", 32'(o_man_min_ext), 32'h0800001);
        chk("full man_max", 32'(o_man_max_ext), 32'({24'hABCDEF, 3'b000}));
        i_rst   = 1'b1;
        i_ready = 1'b1;
        step();
        chk("midrst o_valid", 32'(o_valid), 32'd0);
        chk("midrst o_ready", 32'(o_ready), 32'd1);
        chk("midrst man_min", 32'(o_man_min_ext), 32'd0);
        chk("midrst man_max", 32'(o_man_max_ext), 32'd0);
        chk("midrst eff_sub", 32'(o_eff_sub), 32'd0);
        chk("midrst sign_max", 32'(o_sign_max), 32'd0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        single("post_rst", 1'b1, 1'b0, 24'hFEDCBA, 24'h800001, 8'd1, 27'h2000004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/man_align_shift.md
Name: man_align_shift

Overview:
- Alignment stage of the FP add/sub datapath. Sits directly downstream of the mantissa swap stage.
- Takes the swapped operands (max/min sign and mantissa) and the exponent difference.
- Right-shifts the min mantissa by the exponent difference and produces guard/round/sticky bits. Also flags effective subtraction.
- Two-stage valid/ready pipeline with full backpressure. Feeds the mantissa add/sub stage.

Parameters:
- SIZE_MAN, 24, mantissa width including hidden bit.
- SIZE_EXP, 8, exponent-difference width (unsigned).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  stage can accept input this cycle.
- i_sign_max  in  1  sign of larger-magnitude operand.
- i_sign_min  in  1  sign of smaller-magnitude operand.
- i_man_max  in  SIZE_MAN  larger mantissa.
- i_man_min  in  SIZE_MAN  smaller mantissa.
- i_exp_diff  in  SIZE_EXP  exp_max - exp_min, unsigned.
- o_valid  out  1  output data valid.
- i_ready  in  1  downstream accepts output.
- o_sign_max  out  1  registered sign_max.
- o_eff_sub  out  1  sign_max XOR sign_min.
- o_man_max_ext  out  SIZE_MAN+3  {man_max, 3'b000}.
- o_man_min_ext  out  SIZE_MAN+3  {aligned man_min, G, R, S}.

Behaviour:
- Interface is fixed: one clock, i_clk; reset i_rst is synchronous and active-high.
- Stage 1 (S1) is an input register: valid flag s1_v plus the captured fields.
- Stage 2 (S2) is the output register: s2_v drives o_valid and holds the shifted results.
- Transfer rules:
  - A transfer occurs on a port when valid && ready are both high at a rising edge.
  - s2_free = !s2_v || i_ready.
  - s1_free = !s1_v || s2_free.
  - o_ready = s1_free (combinational, no dependence on i_valid).
  - If s1_free, S1 loads the inputs and s1_v <= i_valid; otherwise S1 holds.
  - If s2_free, S2 loads the shift result of S1 and s2_v <= s1_v; otherwise S2 holds.
- Latency: 2 cycles from input transfer to o_valid with no stall. Throughput is 1 per cycle with i_ready held high.
- Outputs must stay stable while o_valid && !i_ready.
- Shift arithmetic, computed combinationally from S1 into S2:
  - ext = {man_min, 2'b00}, width SIZE_MAN+2.
  - d = i_exp_diff (from S1).
  - If d < SIZE_MAN+2: sh = ext >> d; S = OR of the d LSBs of ext shifted out.
  - If d >= SIZE_MAN+2: sh = 0; S = |man_min.
  - o_man_min_ext = {sh, S}.
  - The full SIZE_EXP range of d is legal; no wrap-around or modulo shifting.
- o_man_max_ext = {man_max, 3'b000}.
- o_eff_sub = sign_max ^ sign_min. o_sign_max passes through.
- Reset:
  - On a rising edge with i_rst=1: s1_v=0, s2_v=0, and all data registers = 0.
  - All outputs read 0 in the cycle after reset; o_ready=1.
  - Reset mid-operation discards in-flight data with no output transfer.
  - Reset has priority over a simultaneous input transfer.
- Simultaneous events:
  - When full (s1_v=s2_v=1) and i_ready=1, an input transfer in the same cycle is accepted and the pipeline stays full.
  - Bubbles (i_valid=0) propagate as s*_v=0.
- Data fields in S2 update only when s2_free. Content while o_valid=0 is don't-care for checking.

Test Plan:
- Reset, then man_min=24'h800001, man_max=24'hFFFFFF, d=0, signs 0/0, i_ready=1 → two cycles later o_valid=1, o_man_min_ext=27'h4000008, o_man_max_ext=27'h7FFFFF8, o_eff_sub=0.
- man_min=24'h800001, d=1 → o_man_min_ext=27'h2000004. Same operand with d=3 → 27'h0800001 (sticky set). Signs 0/1 → o_eff_sub=1.
- d=26, then d=255, man_min=24'h000001 → o_man_min_ext=27'h0000001. With man_min=0 and d=255 → 27'h0000000.
- Back-to-back stream of 8 transfers with i_ready=1 → 8 outputs in order, one per cycle, latency 2. Hold i_ready=0 for 3 cycles mid-stream → o_ready drops after two entries are buffered, outputs stay stable, no loss or duplication after release.
- Assert i_rst while the pipeline is full → next cycle o_valid=0, o_ready=1, outputs all 0. A subsequent input emerges with correct data after 2 cycles.
- i_ready=1 with pipeline full and i_valid=1 every cycle → input, shift and output transfers all occur every cycle with no bubble.
